// File: rtl/cr_cceip_64_df_ob_buf.sv
// -----------------------------------------------------------------------------
// cr_cceip_64_df_ob_buf
//
// Elastic output buffer that sits right after the data-flow mux output of the
// support block. AXI4-stream beats are held in a DEPTH-entry FIFO. The osf
// halt request only stops the output side at a frame boundary, so a frame
// that has started leaving is always finished. Completed output frames are
// counted, and a registered idle flag feeds the support block's idle
// aggregation.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_t*                      upstream AXI4-stream slave (from df mux ob)
//   out_t*                     downstream AXI4-stream master
//   halt                       frame-boundary stop request (sup_osf_halt)
//   cnt_clr                    synchronous clear of frm_cnt (wins over count)
//   frm_cnt                    completed output frames, wraps at 16 bits
//   occupancy                  entries currently held
//   halted                     output paused by halt at a frame boundary
//   idle                       registered: empty, at boundary, nothing offered
// -----------------------------------------------------------------------------
module cr_cceip_64_df_ob_buf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  input  logic                     in_tlast,
  input  logic [USER_W-1:0]        in_tuser,
  input  logic [DATA_W/8-1:0]      in_tstrb,
  input  logic [DATA_W-1:0]        in_tdata,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     out_tlast,
  output logic [USER_W-1:0]        out_tuser,
  output logic [DATA_W/8-1:0]      out_tstrb,
  output logic [DATA_W-1:0]        out_tdata,
  input  logic                     halt,
  input  logic                     cnt_clr,
  output logic [15:0]              frm_cnt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     halted,
  output logic                     idle
);

  localparam int AW     = $clog2(DEPTH);
  localparam int OW     = AW + 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = 1 + USER_W + STRB_W + DATA_W;
  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

  typedef enum logic {
    OB_IDLE,
    OB_FRAME
  } ob_state_t;

  // FIFO storage; contents are deliberately left unreset.
  logic [ENT_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [OW-1:0] occ_reg;
  logic [OW-1:0] occ_next;
  ob_state_t     state_reg;
  logic [15:0]   frm_cnt_reg;
  logic          idle_reg;

  logic             push;
  logic             pop;
  logic             at_boundary;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;

  assign at_boundary = (state_reg == OB_IDLE);

  // Ready comes from the registered count only, so a full FIFO never accepts
  // a beat even when a pop frees a slot in the same cycle.
  assign in_tready = (occ_reg != FULL_CNT) && rst_n;

  // Halt can only hold back the first beat of a frame; mid-frame it is ignored.
  assign out_tvalid = (occ_reg != '0) && !(at_boundary && halt) && rst_n;
  assign halted     = at_boundary && halt && rst_n;

  assign push = in_tvalid && in_tready;
  assign pop  = out_tvalid && out_tready;

  assign wr_entry = {in_tlast, in_tuser, in_tstrb, in_tdata};

  // Combinational read of the head entry: the output beat holds steady while
  // stalled because rd_ptr_reg only moves on a pop.
  assign rd_entry = mem[rd_ptr_reg];
  assign {out_tlast, out_tuser, out_tstrb, out_tdata} = rd_entry;

  assign occ_next = occ_reg + OW'(push) - OW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      state_reg   <= OB_IDLE;
      frm_cnt_reg <= '0;
      idle_reg    <= 1'b1;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap on their own.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      occ_reg <= occ_next;

      // Frame tracking: any popped tlast lands back on a boundary, any other
      // pop means a frame is in flight.
      case (state_reg)
        OB_IDLE: begin
          if (pop && !out_tlast) begin
            state_reg <= OB_FRAME;
          end
        end
        OB_FRAME: begin
          if (pop && out_tlast) begin
            state_reg <= OB_IDLE;
          end
        end
        default: state_reg <= OB_IDLE;
      endcase

      // Clear wins over a coincident frame completion.
      if (cnt_clr) begin
        frm_cnt_reg <= '0;
      end else if (pop && out_tlast) begin
        frm_cnt_reg <= frm_cnt_reg + 16'd1;
      end

      idle_reg <= (occ_reg == '0) && at_boundary && !in_tvalid;
    end
  end

  assign occupancy = occ_reg;
  assign frm_cnt   = frm_cnt_reg;
  assign idle      = idle_reg;

endmodule

// File: tb/tb_cr_cceip_64_df_ob_buf.sv
// -----------------------------------------------------------------------------
// tb_cr_cceip_64_df_ob_buf
//
// Directed bench for the df output buffer. Stimulus pushes the expected beat
// into a scoreboard queue whenever an input handshake is issued; a separate
// monitor on the falling edge pops and compares every output handshake.
// Status outputs (occupancy, frm_cnt, idle, halted, ready/valid) are compared
// against hand-computed values at fixed points of each scenario.
// -----------------------------------------------------------------------------
module tb_cr_cceip_64_df_ob_buf;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int USER_W = 8;
  localparam int OW     = $clog2(DEPTH) + 1;

  logic                  clk;
  logic                  rst_n;
  logic                  in_tvalid;
  logic                  in_tready;
  logic                  in_tlast;
  logic [USER_W-1:0]     in_tuser;
  logic [DATA_W/8-1:0]   in_tstrb;
  logic [DATA_W-1:0]     in_tdata;
  logic                  out_tvalid;
  logic                  out_tready;
  logic                  out_tlast;
  logic [USER_W-1:0]     out_tuser;
  logic [DATA_W/8-1:0]   out_tstrb;
  logic [DATA_W-1:0]     out_tdata;
  logic                  halt;
  logic                  cnt_clr;
  logic [15:0]           frm_cnt;
  logic [OW-1:0]         occupancy;
  logic                  halted;
  logic                  idle;

  cr_cceip_64_df_ob_buf #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .USER_W(USER_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tlast  (in_tlast),
    .in_tuser  (in_tuser),
    .in_tstrb  (in_tstrb),
    .in_tdata  (in_tdata),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast),
    .out_tuser (out_tuser),
    .out_tstrb (out_tstrb),
    .out_tdata (out_tdata),
    .halt      (halt),
    .cnt_clr   (cnt_clr),
    .frm_cnt   (frm_cnt),
    .occupancy (occupancy),
    .halted    (halted),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          verbose  = 1'b1;
  logic [80:0] exp_q[$];
  logic [80:0] mon_got;
  logic [80:0] mon_exp;

  // Beat layout {tlast, tuser, tstrb, tdata}; every field depends on tag/index
  // so reordering or field corruption shows up in the compare.
  function automatic logic [80:0] mk(input logic last, input logic [7:0] tag, input int i);
    logic [7:0] idx;
    idx = 8'(i);
    mk = {last, tag ^ idx, 8'hFF - idx, tag, 48'h5A5A_0000_C3C3, idx};
  endfunction

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) for acceptance.
  task automatic push_beat(input logic [80:0] b);
    bit ok;
    ok = 1'b0;
    {in_tlast, in_tuser, in_tstrb, in_tdata} = b;
    in_tvalid = 1'b1;
    for (int w = 0; w < 50 && !ok; w++) begin
      if (in_tready) ok = 1'b1;
      else step();
    end
    if (ok) begin
      exp_q.push_back(b);
      if (verbose) $display("push  beat %0h", b);
      step();
    end else begin
      n_checks++;
      $display("FAIL push_timeout: in_tready stayed 0, expected 1 within 50 cycles");
    end
    in_tvalid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been seen by the monitor.
  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 100 && !done; w++) begin
      if (exp_q.size() == 0) done = 1'b1;
      else step();
    end
    if (!done) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Stream n single-beat frames straight through with no backpressure.
  task automatic bulk(input int n);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    verbose = 1'b0;
    halt = 1'b0;
    out_tready = 1'b1;
    in_tvalid = 1'b1;
    while (cnt < n && guard < n + 100) begin
      {in_tlast, in_tuser, in_tstrb, in_tdata} = mk(1'b1, 8'h77, cnt);
      if (in_tready) begin
        exp_q.push_back(mk(1'b1, 8'h77, cnt));
        cnt++;
      end
      step();
      guard++;
    end
    in_tvalid = 1'b0;
    if (cnt != n) begin
      n_checks++;
      $display("FAIL bulk_accept: accepted %0d, expected %0d", cnt, n);
    end
    wait_drain();
    verbose = 1'b1;
    $display("bulk  %0d single-beat frames streamed", n);
  endtask

  // Scoreboard monitor: one compare per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_tvalid && out_tready) begin
      mon_got = {out_tlast, out_tuser, out_tstrb, out_tdata};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_beat: got unexpected beat %0h, expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_beat", mon_got, mon_exp);
        if (verbose) $display("pop   beat %0h", mon_got);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    in_tuser = '0;
    in_tstrb = '0;
    in_tdata = '0;
    out_tready = 1'b0;
    halt = 1'b0;
    cnt_clr = 1'b0;

    // ---- reset state ----
    #1;
    chk("rst_in_tready", 81'(in_tready), 81'(0));
    chk("rst_out_tvalid", 81'(out_tvalid), 81'(0));
    repeat (3) step();
    chk("rst_occupancy", 81'(occupancy), 81'(0));
    chk("rst_frm_cnt", 81'(frm_cnt), 81'(0));
    chk("rst_idle", 81'(idle), 81'(1));
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_tready", 81'(in_tready), 81'(1));

    // ---- single 3-beat frame through an empty FIFO ----
    out_tready = 1'b1;
    chk("t1_empty_out_tvalid", 81'(out_tvalid), 81'(0));
    push_beat(mk(1'b0, 8'hA0, 0));
    chk("t1_latency_out_tvalid", 81'(out_tvalid), 81'(1));
    push_beat(mk(1'b0, 8'hA0, 1));
    push_beat(mk(1'b1, 8'hA0, 2));
    wait_drain();
    chk("t1_occupancy", 81'(occupancy), 81'(0));
    chk("t1_frm_cnt", 81'(frm_cnt), 81'(1));
    chk("t1_idle_at_last_pop", 81'(idle), 81'(0));
    step();
    chk("t1_idle_after", 81'(idle), 81'(1));

    // ---- fill and backpressure ----
    out_tready = 1'b0;
    for (int i = 0; i < 8; i++) push_beat(mk(i == 7, 8'hB0, i));
    chk("t2_full_occupancy", 81'(occupancy), 81'(8));
    chk("t2_full_in_tready", 81'(in_tready), 81'(0));
    {in_tlast, in_tuser, in_tstrb, in_tdata} = mk(1'b0, 8'hB0, 8);
    in_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("t2_hold_in_tready", 81'(in_tready), 81'(0));
      chk("t2_hold_occupancy", 81'(occupancy), 81'(8));
      chk("t2_hold_out_valid", 81'(out_tvalid), 81'(1));
      chk("t2_hold_out_data", {out_tlast, out_tuser, out_tstrb, out_tdata}, mk(1'b0, 8'hB0, 0));
      step();
    end
    out_tready = 1'b1;
    push_beat(mk(1'b0, 8'hB0, 8));
    chk("t2_push_pop_occ_a", 81'(occupancy), 81'(7));
    push_beat(mk(1'b1, 8'hB0, 9));
    chk("t2_push_pop_occ_b", 81'(occupancy), 81'(7));
    wait_drain();
    chk("t2_frm_cnt", 81'(frm_cnt), 81'(3));
    chk("t2_occupancy", 81'(occupancy), 81'(0));

    // ---- halt raised mid-frame ----
    out_tready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(mk(i == 3, 8'hC0, i));
    for (int i = 0; i < 2; i++) push_beat(mk(i == 1, 8'hD0, i));
    chk("t3_occupancy", 81'(occupancy), 81'(6));
    out_tready = 1'b1;
    step();
    step();
    halt = 1'b1;
    #1;
    chk("t3_midframe_valid", 81'(out_tvalid), 81'(1));
    chk("t3_midframe_halted", 81'(halted), 81'(0));
    step();
    chk("t3_beat4_valid", 81'(out_tvalid), 81'(1));
    step();
    chk("t3_boundary_valid", 81'(out_tvalid), 81'(0));
    chk("t3_boundary_halted", 81'(halted), 81'(1));
    chk("t3_boundary_occ", 81'(occupancy), 81'(2));
    chk("t3_boundary_frm_cnt", 81'(frm_cnt), 81'(4));
    step();
    step();
    chk("t3_held_valid", 81'(out_tvalid), 81'(0));
    chk("t3_held_occ", 81'(occupancy), 81'(2));
    halt = 1'b0;
    wait_drain();
    chk("t3_frm_cnt", 81'(frm_cnt), 81'(5));
    chk("t3_occupancy", 81'(occupancy), 81'(0));

    // ---- halt already asserted at a boundary ----
    halt = 1'b1;
    out_tready = 1'b1;
    step();
    chk("t4_idle_before", 81'(idle), 81'(1));
    chk("t4_halted", 81'(halted), 81'(1));
    push_beat(mk(1'b0, 8'hE0, 0));
    chk("t4_idle_drop", 81'(idle), 81'(0));
    push_beat(mk(1'b1, 8'hE0, 1));
    chk("t4_blocked_valid", 81'(out_tvalid), 81'(0));
    chk("t4_blocked_occ", 81'(occupancy), 81'(2));
    step();
    chk("t4_still_blocked", 81'(out_tvalid), 81'(0));
    halt = 1'b0;
    step();
    step();
    chk("t4_released_occ", 81'(occupancy), 81'(0));
    chk("t4_frm_cnt", 81'(frm_cnt), 81'(6));

    // ---- frame counter wrap and clear priority ----
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr", 81'(frm_cnt), 81'(0));
    bulk(65535);
    chk("t5_pre_wrap", 81'(frm_cnt), 81'(16'hFFFF));
    bulk(1);
    chk("t5_wrap", 81'(frm_cnt), 81'(0));
    out_tready = 1'b0;
    push_beat(mk(1'b1, 8'hF0, 0));
    push_beat(mk(1'b1, 8'hF0, 1));
    out_tready = 1'b1;
    step();
    chk("t5_count_one", 81'(frm_cnt), 81'(1));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr_vs_tlast", 81'(frm_cnt), 81'(0));
    chk("t5_occupancy", 81'(occupancy), 81'(0));

    // ---- reset in the middle of a frame ----
    out_tready = 1'b0;
    push_beat(mk(1'b1, 8'h1E, 0));
    for (int i = 0; i < 6; i++) push_beat(mk(1'b0, 8'h60, i));
    out_tready = 1'b1;
    step();
    step();
    out_tready = 1'b0;
    chk("t6_pre_frm_cnt", 81'(frm_cnt), 81'(1));
    chk("t6_pre_occ", 81'(occupancy), 81'(5));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_in_tready", 81'(in_tready), 81'(0));
    chk("t6_rst_out_tvalid", 81'(out_tvalid), 81'(0));
    step();
    chk("t6_rst_occ", 81'(occupancy), 81'(0));
    chk("t6_rst_frm_cnt", 81'(frm_cnt), 81'(0));
    chk("t6_rst_idle", 81'(idle), 81'(1));
    rst_n = 1'b1;
    halt = 1'b1;
    #1;
    chk("t6_post_in_tready", 81'(in_tready), 81'(1));
    chk("t6_post_out_tvalid", 81'(out_tvalid), 81'(0));
    chk("t6_post_halted", 81'(halted), 81'(1));
    halt = 1'b0;
    out_tready = 1'b1;
    push_beat(mk(1'b1, 8'h4B, 0));
    wait_drain();
    chk("t6_fresh_frm_cnt", 81'(frm_cnt), 81'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
